// File: rtl/chroma_key_mixer.sv
// chroma_key_mixer: streaming chroma-key compositor.
// Foreground pixels close enough to the key colour are replaced by the
// co-located background pixel. Key, tolerance and enable are set over a
// small Avalon-MM slave, which also reports the keyed-pixel count of the
// last completed frame.
//
// Handshake semantics (all Avalon-ST ports): a beat transfers on a rising
// clock edge where valid && ready are both high. A source must hold its
// data and flags stable while valid=1 and ready=0. The fg/bg ready outputs
// may depend combinationally on the head valid/sop flags.
module chroma_key_mixer #(
    parameter logic [23:0] KEY_DEFAULT = 24'h00FF00,
    parameter logic [9:0]  TOL_DEFAULT = 10'd96,
    parameter int          CNT_W       = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] fg_data,
    input  logic        fg_sop,
    input  logic        fg_eop,
    input  logic        fg_valid,
    output logic        fg_ready,
    input  logic [23:0] bg_data,
    input  logic        bg_sop,
    input  logic        bg_eop,
    input  logic        bg_valid,
    output logic        bg_ready,
    output logic [23:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [1:0]  csr_address,
    input  logic        csr_write,
    input  logic        csr_read,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic        dbg_state
);

    typedef enum logic {ST_SEEK = 1'b0, ST_RUN = 1'b1} state_e;

    state_e state_q, state_d;
    logic   advance, consume, fg_rdy, bg_rdy;

    // CSR state
    logic             en_q;
    logic [23:0]      key_q;
    logic [9:0]       tol_q;
    logic [CNT_W-1:0] count_q, cnt_q;

    // Pipeline stage registers
    logic        s1_valid_q, s1_sop_q, s1_eop_q, s1_en_q;
    logic [23:0] s1_fg_q, s1_bg_q;
    logic [9:0]  s1_tol_q;
    logic [7:0]  s1_dr_q, s1_dg_q, s1_db_q;
    logic        s2_valid_q, s2_sop_q, s2_eop_q, s2_keyed_q;
    logic [23:0] s2_fg_q, s2_bg_q;
    logic        s3_valid_q, s3_sop_q, s3_eop_q, s3_keyed_q;
    logic [23:0] s3_data_q;

    logic [9:0]  s1_sum;
    logic        out_hs;
    logic        unused_wdata;

    assign unused_wdata = ^csr_writedata[31:24];

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Whole pipe moves together; it only holds when the output is stalled.
    assign advance = !s3_valid_q || out_ready;
    assign out_hs  = s3_valid_q && out_ready;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_SEEK;
        else       state_q <= state_d;
    end

    // FSM next state and stream readies: SEEK drops non-sop heads, RUN pairs beats
    always_comb begin
        state_d = state_q;
        fg_rdy  = 1'b0;
        bg_rdy  = 1'b0;
        consume = 1'b0;
        case (state_q)
            ST_SEEK: begin
                fg_rdy = fg_valid && !fg_sop;
                bg_rdy = bg_valid && !bg_sop;
                if (fg_valid && fg_sop && bg_valid && bg_sop) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (fg_valid && bg_valid) begin
                    if (fg_sop != bg_sop) begin
                        state_d = ST_SEEK;
                    end else if (advance) begin
                        consume = 1'b1;
                        fg_rdy  = 1'b1;
                        bg_rdy  = 1'b1;
                    end
                end
            end
            default: state_d = ST_SEEK;
        endcase
    end

    assign fg_ready  = fg_rdy && !reset;
    assign bg_ready  = bg_rdy && !reset;
    assign dbg_state = (state_q == ST_RUN);

    assign s1_sum = {2'b00, s1_dr_q} + {2'b00, s1_dg_q} + {2'b00, s1_db_q};

    // Three-stage datapath: distance per channel, threshold, select
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0; s1_sop_q <= 1'b0; s1_eop_q <= 1'b0; s1_en_q <= 1'b0;
            s1_fg_q    <= '0;   s1_bg_q  <= '0;   s1_tol_q <= '0;
            s1_dr_q    <= '0;   s1_dg_q  <= '0;   s1_db_q  <= '0;
            s2_valid_q <= 1'b0; s2_sop_q <= 1'b0; s2_eop_q <= 1'b0; s2_keyed_q <= 1'b0;
            s2_fg_q    <= '0;   s2_bg_q  <= '0;
            s3_valid_q <= 1'b0; s3_sop_q <= 1'b0; s3_eop_q <= 1'b0; s3_keyed_q <= 1'b0;
            s3_data_q  <= '0;
        end else if (advance) begin
            s1_valid_q <= consume;
            s1_sop_q   <= fg_sop;
            s1_eop_q   <= fg_eop;
            s1_fg_q    <= fg_data;
            s1_bg_q    <= bg_data;
            s1_en_q    <= en_q;
            s1_tol_q   <= tol_q;
            s1_dr_q    <= abs_diff(fg_data[23:16], key_q[23:16]);
            s1_dg_q    <= abs_diff(fg_data[15:8],  key_q[15:8]);
            s1_db_q    <= abs_diff(fg_data[7:0],   key_q[7:0]);

            s2_valid_q <= s1_valid_q;
            s2_sop_q   <= s1_sop_q;
            s2_eop_q   <= s1_eop_q;
            s2_fg_q    <= s1_fg_q;
            s2_bg_q    <= s1_bg_q;
            s2_keyed_q <= s1_en_q && (s1_sum < s1_tol_q);

            s3_valid_q <= s2_valid_q;
            s3_sop_q   <= s2_sop_q;
            s3_eop_q   <= s2_eop_q;
            s3_keyed_q <= s2_keyed_q;
            s3_data_q  <= s2_keyed_q ? s2_bg_q : s2_fg_q;
        end
    end

    assign out_valid = s3_valid_q;
    assign out_data  = s3_data_q;
    assign out_sop   = s3_sop_q;
    assign out_eop   = s3_eop_q;

    // Keyed-pixel counter; the running count is published to COUNT at end of frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            count_q <= '0;
        end else if (out_hs) begin
            if (s3_eop_q) begin
                count_q <= cnt_q + {{(CNT_W-1){1'b0}}, s3_keyed_q};
                cnt_q   <= '0;
            end else begin
                cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, s3_keyed_q};
            end
        end
    end

    // CSR writes; COUNT is read-only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q  <= 1'b1;
            key_q <= KEY_DEFAULT;
            tol_q <= TOL_DEFAULT;
        end else if (csr_write) begin
            case (csr_address)
                2'd0:    en_q  <= csr_writedata[0];
                2'd1:    key_q <= csr_writedata[23:0];
                2'd2:    tol_q <= csr_writedata[9:0];
                default: ;
            endcase
        end
    end

    // Registered CSR read; samples pre-edge values so same-cycle updates read old
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csr_readdata <= '0;
        end else if (csr_read) begin
            case (csr_address)
                2'd0:    csr_readdata <= {31'b0, en_q};
                2'd1:    csr_readdata <= {8'b0, key_q};
                2'd2:    csr_readdata <= {22'b0, tol_q};
                default: csr_readdata <= {{(32-CNT_W){1'b0}}, count_q};
            endcase
        end
    end

endmodule

// File: tb/tb_chroma_key_mixer.sv
// Directed bench for chroma_key_mixer with a source model per stream,
// an expected-output queue and a reference keying model.
module tb_chroma_key_mixer;

    localparam logic [23:0] KEY_DEF = 24'h00FF00;
    localparam logic [9:0]  TOL_DEF = 10'd96;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] fg_data, bg_data, out_data;
    logic        fg_sop, fg_eop, fg_valid, fg_ready;
    logic        bg_sop, bg_eop, bg_valid, bg_ready;
    logic        out_sop, out_eop, out_valid, out_ready;
    logic [1:0]  csr_address;
    logic        csr_write, csr_read;
    logic [31:0] csr_writedata, csr_readdata;
    logic        dbg_state;

    always #5 clk = ~clk;

    chroma_key_mixer dut (
        .clk(clk), .reset(reset),
        .fg_data(fg_data), .fg_sop(fg_sop), .fg_eop(fg_eop), .fg_valid(fg_valid), .fg_ready(fg_ready),
        .bg_data(bg_data), .bg_sop(bg_sop), .bg_eop(bg_eop), .bg_valid(bg_valid), .bg_ready(bg_ready),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_valid(out_valid), .out_ready(out_ready),
        .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .dbg_state(dbg_state)
    );

    // {sop, eop, data}
    logic [25:0] fg_src_q[$];
    logic [25:0] bg_src_q[$];
    logic [25:0] exp_q[$];

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    int          exp_keyed = 0;
    int          t_in = -1;
    logic        lat_arm = 1'b0;
    logic        prev_stall = 1'b0;
    logic [25:0] held = '0;
    logic [23:0] m_key = KEY_DEF;
    logic [9:0]  m_tol = TOL_DEF;
    logic        m_en = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic int ad(input logic [7:0] a, input logic [7:0] b);
        int x = int'(a) - int'(b);
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic is_keyed(input logic [23:0] px);
        int d = ad(px[23:16], m_key[23:16]) + ad(px[15:8], m_key[15:8]) + ad(px[7:0], m_key[7:0]);
        return m_en && (d < int'(m_tol));
    endfunction

    task automatic add_pair(input logic [23:0] f, input logic [23:0] b,
                            input logic fs, input logic fe, input logic bs, input logic be);
        logic k;
        k = is_keyed(f);
        fg_src_q.push_back({fs, fe, f});
        bg_src_q.push_back({bs, be, b});
        exp_q.push_back({fs, fe, k ? b : f});
        if (k) exp_keyed++;
    endtask

    task automatic add_bg_junk(input logic [23:0] b, input logic be);
        bg_src_q.push_back({1'b0, be, b});
    endtask

    task automatic drive();
        if (!reset && fg_src_q.size() > 0) begin
            fg_valid = 1'b1;
            {fg_sop, fg_eop, fg_data} = fg_src_q[0];
        end else begin
            fg_valid = 1'b0; fg_sop = 1'b0; fg_eop = 1'b0; fg_data = '0;
        end
        if (!reset && bg_src_q.size() > 0) begin
            bg_valid = 1'b1;
            {bg_sop, bg_eop, bg_data} = bg_src_q[0];
        end else begin
            bg_valid = 1'b0; bg_sop = 1'b0; bg_eop = 1'b0; bg_data = '0;
        end
        out_ready = (stall_cnt == 0);
    endtask

    // One clock: sample handshakes/outputs at negedge, then update sources after posedge
    task automatic tick();
        logic fg_hs, bg_hs, out_hs;
        logic [25:0] e;
        @(negedge clk);
        cyc++;
        fg_hs  = fg_valid && fg_ready;
        bg_hs  = bg_valid && bg_ready;
        out_hs = out_valid && out_ready;
        if (!reset) begin
            if (prev_stall) begin
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                check("stall_data", {6'b0, out_sop, out_eop, out_data}, {6'b0, held});
            end
            prev_stall = out_valid && !out_ready;
            held = {out_sop, out_eop, out_data};
            if (lat_arm && fg_hs) begin
                t_in = cyc;
                lat_arm = 1'b0;
            end
            if (out_hs) begin
                check("out_avail", {31'b0, (exp_q.size() != 0)}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_beat", {6'b0, out_sop, out_eop, out_data}, {6'b0, e});
                end
                if (t_in >= 0) begin
                    check("latency", cyc - t_in, 32'd3);
                    t_in = -1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (fg_hs) void'(fg_src_q.pop_front());
        if (bg_hs) void'(bg_src_q.pop_front());
        drive();
        if (stall_cnt > 0) stall_cnt--;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || fg_src_q.size() != 0 || bg_src_q.size() != 0) && n < max) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (4) tick();
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        tick();
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a; csr_read = 1'b1;
        tick();
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [23:0] f;

        csr_address = '0; csr_write = 1'b0; csr_read = 1'b0; csr_writedata = '0;
        out_ready = 1'b1;
        fg_valid = 1'b1; fg_sop = 1'b0; fg_eop = 1'b0; fg_data = 24'h000123;
        bg_valid = 1'b1; bg_sop = 1'b0; bg_eop = 1'b0; bg_data = 24'h000456;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fg_ready", {31'b0, fg_ready}, 32'd0);
        check("rst_bg_ready", {31'b0, bg_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out", {6'b0, out_sop, out_eop, out_data}, 32'd0);
        check("rst_readdata", csr_readdata, 32'd0);
        check("rst_state", {31'b0, dbg_state}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive();

        csr_rd(2'd0, rd); check("def_ctrl", rd, 32'd1);
        csr_rd(2'd1, rd); check("def_key", rd, 32'h0000FF00);
        csr_rd(2'd2, rd); check("def_tol", rd, 32'd96);
        csr_rd(2'd3, rd); check("def_count", rd, 32'd0);

        // Keying cases around the default key and the tolerance boundary
        exp_keyed = 0;
        lat_arm = 1'b1;
        add_pair(24'h10F020, 24'h123456, 1'b1, 1'b0, 1'b1, 1'b0);
        add_pair(24'h808080, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0);
        add_pair(24'h00FF60, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0);
        add_pair(24'h00FF5F, 24'h123456, 1'b0, 1'b1, 1'b0, 1'b1);
        drain(200);
        check("key_state_run", {31'b0, dbg_state}, 32'd1);
        csr_rd(2'd3, rd); check("key_count", rd, exp_keyed);

        // 16-pixel frame with a 5-cycle output stall mid-frame
        exp_keyed = 0;
        for (int i = 0; i < 16; i++) begin
            if ((i % 3) == 0)
                f = {8'($urandom_range(0, 30)), 8'(255 - $urandom_range(0, 30)), 8'($urandom_range(0, 30))};
            else
                f = 24'($urandom_range(0, 32'h00FFFFFF));
            add_pair(f, 24'($urandom), i == 0, i == 15, i == 0, i == 15);
        end
        repeat (6) tick();
        stall_cnt = 5;
        drain(300);
        csr_rd(2'd3, rd); check("bp_count", rd, exp_keyed);

        // Background leads with three non-sop beats
        add_bg_junk(24'hDEAD01, 1'b0);
        add_bg_junk(24'hDEAD02, 1'b0);
        add_bg_junk(24'hDEAD03, 1'b0);
        for (int i = 0; i < 4; i++)
            add_pair(24'($urandom), 24'($urandom), i == 0, i == 3, i == 0, i == 3);
        drain(200);

        // Foreground sop arrives two beats before background sop
        for (int i = 0; i < 4; i++)
            add_pair(24'($urandom), 24'($urandom), i == 0, i == 3, i == 0, 1'b0);
        add_bg_junk(24'hBEEF04, 1'b0);
        add_bg_junk(24'hBEEF05, 1'b1);
        for (int i = 0; i < 4; i++)
            add_pair(24'($urandom), 24'($urandom), i == 0, i == 3, i == 0, i == 3);
        drain(200);

        // Frame with exactly five key-colour pixels
        exp_keyed = 0;
        for (int i = 0; i < 16; i++)
            add_pair(((i % 3) == 1) && (i < 14) ? 24'h00FF00 : 24'h808080, 24'($urandom),
                     i == 0, i == 15, i == 0, i == 15);
        drain(300);
        csr_rd(2'd3, rd); check("count5", rd, exp_keyed);
        csr_wr(2'd3, 32'd99);
        csr_rd(2'd3, rd); check("count_ro", rd, exp_keyed);

        // Same frame with keying disabled
        csr_wr(2'd0, 32'd0);
        m_en = 1'b0;
        exp_keyed = 0;
        for (int i = 0; i < 16; i++)
            add_pair(((i % 3) == 1) && (i < 14) ? 24'h00FF00 : 24'h808080, 24'($urandom),
                     i == 0, i == 15, i == 0, i == 15);
        drain(300);
        csr_rd(2'd3, rd); check("count_dis", rd, exp_keyed);
        csr_rd(2'd0, rd); check("ctrl_off", rd, 32'd0);
        csr_wr(2'd0, 32'hFFFF_FFFF);
        m_en = 1'b1;
        csr_rd(2'd0, rd); check("ctrl_unused", rd, 32'd1);

        // New key and a tight tolerance, including d == TOL
        csr_wr(2'd1, 32'hAAFF_0000);
        m_key = 24'hFF0000;
        csr_rd(2'd1, rd); check("key_wr", rd, 32'h00FF0000);
        csr_wr(2'd2, 32'hFFFF_FC14);
        m_tol = 10'd20;
        csr_rd(2'd2, rd); check("tol_wr", rd, 32'd20);
        exp_keyed = 0;
        add_pair(24'hFF0000, 24'h0A0B0C, 1'b1, 1'b0, 1'b1, 1'b0);
        add_pair(24'hF00A00, 24'h0A0B0C, 1'b0, 1'b0, 1'b0, 1'b0);
        add_pair(24'hFA0500, 24'h0A0B0C, 1'b0, 1'b0, 1'b0, 1'b0);
        add_pair(24'hEC0000, 24'h0A0B0C, 1'b0, 1'b0, 1'b0, 1'b0);
        add_pair(24'hEB0000, 24'h0A0B0C, 1'b0, 1'b1, 1'b0, 1'b1);
        drain(200);
        csr_rd(2'd3, rd); check("tol_count", rd, exp_keyed);

        // Read and write of the same register in one cycle returns the old value
        csr_address = 2'd2; csr_writedata = 32'd50; csr_write = 1'b1; csr_read = 1'b1;
        tick();
        csr_write = 1'b0; csr_read = 1'b0;
        check("rw_old", csr_readdata, 32'd20);
        m_tol = 10'd50;
        csr_rd(2'd2, rd); check("rw_new", rd, 32'd50);

        // Reset while the pipe holds stalled pixels
        for (int i = 0; i < 4; i++)
            add_pair(24'($urandom), 24'($urandom), i == 0, 1'b0, i == 0, 1'b0);
        stall_cnt = 30;
        repeat (6) tick();
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_data", {8'b0, out_data}, 32'd0);
        fg_src_q.delete();
        bg_src_q.delete();
        exp_q.delete();
        stall_cnt = 0;
        prev_stall = 1'b0;
        t_in = -1;
        repeat (2) tick();
        reset = 1'b0;
        drive();
        m_key = KEY_DEF;
        m_tol = TOL_DEF;
        m_en = 1'b1;
        csr_rd(2'd1, rd); check("post_rst_key", rd, 32'h0000FF00);
        csr_rd(2'd2, rd); check("post_rst_tol", rd, 32'd96);
        csr_rd(2'd3, rd); check("post_rst_count", rd, 32'd0);
        exp_keyed = 0;
        lat_arm = 1'b1;
        for (int i = 0; i < 6; i++)
            add_pair((i % 2) == 0 ? 24'h05F805 : 24'($urandom), 24'($urandom),
                     i == 0, i == 5, i == 0, i == 5);
        drain(200);
        csr_rd(2'd3, rd); check("post_rst_frame_count", rd, exp_keyed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chroma_key_mixer.md
# chroma_key_mixer

Streaming pixel compositor that sits between the video-in path (camera frames decoded from the video decoder, converted to 24-bit RGB) and the MTL display output stream of the Nios system. Each foreground pixel is compared against a programmable key colour. Pixels within tolerance are replaced by the co-located pixel of a background stream, for example an image read from SDRAM or SRAM. Key colour, tolerance and enable are set by the Nios through a small Avalon-MM slave, which also reports the number of keyed pixels per frame.

## Interface
- KEY_DEFAULT, 24'h00FF00, key colour {R,G,B} loaded at reset
- TOL_DEFAULT, 10'd96, tolerance loaded at reset
- CNT_W, 20, width of keyed-pixel counter (800x480 fits)

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- fg_data / fg_sop / fg_eop / fg_valid  in  24/1/1/1  foreground Avalon-ST sink
- fg_ready  out  1  foreground accept
- bg_data / bg_sop / bg_eop / bg_valid  in  24/1/1/1  background Avalon-ST sink
- bg_ready  out  1  background accept
- out_data / out_sop / out_eop / out_valid  out  24/1/1/1  composited Avalon-ST source
- out_ready  in  1  downstream accept
- csr_address  in  2  register select
- csr_write, csr_read  in  1  strobes
- csr_writedata  in  32
- csr_readdata  out  32  registered, valid 1 cycle after csr_read

## Operation
- Registers:
  - 0 CTRL: bit0 enable, reset 1.
  - 1 KEY: [23:0], reset KEY_DEFAULT.
  - 2 TOL: [9:0], reset TOL_DEFAULT.
  - 3 COUNT: RO, keyed pixels of the last completed frame, reset 0.
  - Unused bits read 0. Writes to COUNT are ignored.
- Sync FSM, states SEEK and RUN. The state after reset is SEEK.
  - SEEK: each stream whose head beat is valid with sop=0 is popped and dropped (its ready=1 and nothing enters the pipe). A stream whose head has sop=1 is held.
  - SEEK -> RUN when both heads are valid with sop=1.
  - RUN: a pair is consumed only when fg_valid, bg_valid and advance are all high. fg_ready and bg_ready are asserted together.
  - RUN, pair with fg_sop != bg_sop: the pair is not consumed and the state goes to SEEK.
  - RUN, consumed pair with fg_eop=1: the state stays RUN. bg_eop is ignored.
- Pipeline, 3 stages:
  - S1: captures fg, bg, sop/eop and the current KEY/TOL/enable. Computes |R-Kr|, |G-Kg| and |B-Kb|, 8 bits each.
  - S2: 10-bit sum d, zero-extended with no saturation. keyed = enable && (d < TOL). The comparison is strict, so d == TOL is not keyed.
  - S3: out_data = keyed ? bg : fg. sop/eop are taken from fg.
- advance = !out_valid || out_ready. All stages hold when advance=0. Bubbles propagate as invalid stages.
- Counter: increments on each output handshake with keyed=1. On a handshake with out_eop=1, COUNT <= counter (+1 if that pixel is keyed) and the counter clears.
- CSR writes take effect for pixels entering S1 on the next cycle. Changes mid-frame are allowed.

## Timing
- Latency: an accepted pair appears on out_* 3 cycles later when out_ready stays high. Throughput is 1 pixel/clk.
- Reset (async) forces: out_valid=0, out_data=0, out_sop=0, out_eop=0, csr_readdata=0, all pipe valids 0, counter 0, CSR registers to defaults, state SEEK.
- fg_ready/bg_ready are combinational from state, head flags and advance. They are 0 while reset is asserted.
- out_* must stay stable while out_valid=1 and out_ready=0.
- A CSR read and a COUNT update in the same cycle return the old COUNT.
- When csr_write and csr_read hit the same address in the same cycle, the read returns the old value.

## Test plan
- Keying, KEY=00FF00, TOL=96, bg=123456:
  - fg=10F020 (d=63) -> out=123456.
  - fg=808080 -> out=808080.
  - fg with d=96 exactly -> out=fg.
- Backpressure: stream a 16-pixel frame with out_ready toggling 0 for 5 cycles mid-frame -> all 16 pixels appear in order, none duplicated, and out_data stays stable while stalled.
- Misalignment: bg leads with 3 non-sop beats, then sop; fg starts at sop -> the 3 bg beats are dropped and the first output beat has sop=1 with the correct pair.
- Sop mismatch in RUN: fg sop arrives 2 beats before bg sop -> SEEK is re-entered, 2 bg beats are dropped, and the output resumes aligned.
- Count/enable:
  - 16-pixel frame with 5 keyed pixels -> COUNT reads 5 after eop.
  - Repeat with CTRL=0 -> out equals fg for every pixel and COUNT reads 0.
- Reset mid-frame: assert reset with 2 pixels in the pipe -> out_valid=0 immediately, KEY/TOL read their defaults, and the next frame is output correctly from sop.
